// File: rtl/rr_stream_scheduler_pkg.sv
// Shared types and helpers for the round-robin stream scheduler.
// Also defines the RR_SLICE packed-bus slice-select macro.
package rr_stream_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  function automatic int gw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cw_f(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

`ifndef RR_SLICE
`define RR_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

// File: rtl/rr_ptr_wrap.sv
// Combinational next-index helper: idx+1, wrapping from NUM_SRC-1 back to 0.
module rr_ptr_wrap
  import rr_stream_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int GW = gw_f(NUM_SRC)
) (
  input  logic [GW-1:0] idx_i,
  output logic [GW-1:0] next_o
);

  always_comb begin
    next_o = idx_i + GW'(1);
    if (idx_i == GW'(NUM_SRC - 1)) next_o = '0;
  end

endmodule

// File: rtl/rr_stream_scheduler.sv
// Merges NUM_SRC req/ack sources into one downstream port in strict rotation.
// Optional source-skip on stalled acks is enabled by defining RR_SCHED_TIMEOUT_EN.
module rr_stream_scheduler
  import rr_stream_scheduler_pkg::*;
#(
  parameter int data_width = 32,
  parameter int NUM_SRC    = 4,
  parameter int TIMEOUT    = 16,
  localparam int GW = gw_f(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [NUM_SRC-1:0]           src_req,
  input  logic [NUM_SRC-1:0]           src_ack,
  input  logic [data_width*NUM_SRC-1:0] src_din,
  input  logic                         dst_req,
  output logic                         dst_ack,
  output logic [data_width-1:0]        dst_dout,
  output logic [GW-1:0]                grant_id,
  output logic                         busy,
  output logic                         timeout,
  output logic [1:0]                   dbg_state
);

  if (NUM_SRC < 2) begin : g_bad_num_src
    $error("NUM_SRC must be >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be >= 2");
  end

  // Handshake: src_req[i] stays high until a one-cycle src_ack[i] is seen while
  // granted; dst_ack is a one-cycle pulse answering a level dst_req.
  state_e                 state_q, state_d;
  logic [GW-1:0]          ptr_q, ptr_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [NUM_SRC-1:0]     src_req_q, src_req_d;
  logic                   dst_ack_q, dst_ack_d;
  logic [data_width-1:0]  dout_q, dout_d;
  logic                   busy_q, busy_d;
  logic [GW-1:0]          ptr_next;
  logic                   ack_hit;

  rr_ptr_wrap #(.NUM_SRC(NUM_SRC)) u_ptr_wrap (.idx_i(ptr_q), .next_o(ptr_next));

`ifdef RR_SCHED_TIMEOUT_EN
  localparam int CW = cw_f(TIMEOUT);
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          timeout_q, timeout_d;
  logic [GW-1:0] grant_next;

  rr_ptr_wrap #(.NUM_SRC(NUM_SRC)) u_skip_wrap (.idx_i(grant_q), .next_o(grant_next));
`endif

  // An ack only counts on the granted index while its request is still up.
  assign ack_hit = src_ack[grant_q] & src_req_q[grant_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    src_req_d = src_req_q;
    dst_ack_d = 1'b0;
    dout_d    = dout_q;
    busy_d    = busy_q;
`ifdef RR_SCHED_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dst_req) begin
          grant_d          = ptr_q;
          src_req_d        = '0;
          src_req_d[ptr_q] = 1'b1;
          busy_d           = 1'b1;
`ifdef RR_SCHED_TIMEOUT_EN
          wcnt_d           = '0;
`endif
          state_d          = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_hit) begin
          dout_d    = `RR_SLICE(src_din, int'(grant_q), data_width);
          src_req_d = '0;
          if (dst_req) begin
            dst_ack_d = 1'b1;
            state_d   = ST_ACK;
          end else begin
            state_d   = ST_HOLD;
          end
        end
`ifdef RR_SCHED_TIMEOUT_EN
        else if (wcnt_q == CW'(TIMEOUT - 1)) begin
          src_req_d = '0;
          timeout_d = 1'b1;
          ptr_d     = grant_next;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
`endif
      end
      ST_HOLD: begin
        if (dst_req) begin
          dst_ack_d = 1'b1;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d   = ptr_next;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      src_req_q <= '0;
      dst_ack_q <= 1'b0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
`ifdef RR_SCHED_TIMEOUT_EN
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      src_req_q <= src_req_d;
      dst_ack_q <= dst_ack_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
`ifdef RR_SCHED_TIMEOUT_EN
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign src_req   = src_req_q;
  assign dst_ack   = dst_ack_q;
  assign dst_dout  = dout_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;
`ifdef RR_SCHED_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_stream_scheduler.sv
// Directed bench for rr_stream_scheduler: auto-acking producers feed a scoreboard,
// the monitor checks every delivered token against expected data and rotation.
module tb_rr_stream_scheduler;

  localparam int W  = 32;
  localparam int NS = 4;

  logic            clk;
  logic            rst;
  logic [NS-1:0]   src_req;
  logic [NS-1:0]   src_ack;
  logic [W*NS-1:0] src_din;
  logic            dst_req;
  logic            dst_ack;
  logic [W-1:0]    dst_dout;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout;
  logic [1:0]      dbg_state;

  rr_stream_scheduler #(.data_width(W), .NUM_SRC(NS), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_ack(src_ack), .src_din(src_din),
    .dst_req(dst_req), .dst_ack(dst_ack), .dst_dout(dst_dout), .grant_id(grant_id),
    .busy(busy), .timeout(timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- counters / scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           src_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- producers ----------------
  logic [NS-1:0] auto_en;
  logic [NS-1:0] auto_ack;
  logic [NS-1:0] man_ack;
  int            seq [NS];
  int            cnt [NS];

  assign src_ack = auto_ack | man_ack;
  for (genvar g = 0; g < NS; g++) begin : g_din
    assign src_din[g*W +: W] = W'(g * 1000 + seq[g]);
  end

  // Each producer acks on the second cycle it sees its request high.
  initial begin
    auto_ack = '0;
    for (int i = 0; i < NS; i++) begin
      seq[i] = 0;
      cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (auto_ack[i]) begin
          auto_ack[i] = 1'b0;
          seq[i]++;
          cnt[i] = 0;
        end else if (auto_en[i] && src_req[i]) begin
          if (cnt[i] >= 1) begin
            auto_ack[i] = 1'b1;
            exp_q.push_back(W'(i * 1000 + seq[i]));
            src_q.push_back(i);
          end else begin
            cnt[i]++;
          end
        end else begin
          cnt[i] = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int       ack_count = 0;
  int       rot_base  = 0;
  int       base_cnt  = 0;
  logic     gap_chk   = 1'b0;
  logic     have_last = 1'b0;
  int       first_cyc = 0;
  int       last_cyc  = 0;
  logic     prev_ack  = 1'b0;
  logic [W-1:0] last_exp = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!gap_chk) have_last = 1'b0;
      if (dst_ack) begin
        int exp_src;
        exp_src = (rot_base + (ack_count - base_cnt)) % NS;
        check("ack_one_cycle", 32'(prev_ack), 32'd0);
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          last_exp = exp_q.pop_front();
          check("dst_dout", dst_dout, last_exp);
          check("src_order", 32'(src_q.pop_front()), 32'(exp_src));
        end
        check("grant_at_ack", 32'(grant_id), 32'(exp_src));
        if (gap_chk) begin
          if (have_last) check("ack_gap", 32'(cyc - last_cyc), 32'd4);
          else first_cyc = cyc;
          last_cyc  = cyc;
          have_last = 1'b1;
        end
        ack_count++;
      end
      prev_ack = dst_ack;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acks(input int n);
    int target;
    target = ack_count + n;
    for (int k = 0; k < n * 8 + 40 && ack_count < target; k++) @(negedge clk);
    check("wait_acks", 32'(ack_count), 32'(target));
    dst_req = 1'b0;
  endtask

  task automatic run_tokens(input int n);
    dst_req = 1'b1;
    wait_acks(n);
  endtask

  task automatic wait_src_req(input int idx);
    for (int k = 0; k < 60 && !src_req[idx]; k++) @(negedge clk);
    check("wait_src_req", 32'(src_req[idx]), 32'd1);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_src_req"},  32'(src_req),   32'd0);
    check({pfx, "_dst_ack"},  32'(dst_ack),   32'd0);
    check({pfx, "_dst_dout"}, dst_dout,       32'd0);
    check({pfx, "_grant_id"}, 32'(grant_id),  32'd0);
    check({pfx, "_busy"},     32'(busy),      32'd0);
    check({pfx, "_timeout"},  32'(timeout),   32'd0);
    check({pfx, "_state"},    32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] held;
    int           start_cnt;
    int           span;
    int           hi;
    rst     = 1'b1;
    dst_req = 1'b0;
    auto_en = '0;
    man_ack = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    // rotation with gap check: sources 0,1,2,3 x3
    auto_en = 4'hF;
    gap_chk = 1'b1;
    run_tokens(12);
    gap_chk = 1'b0;
    @(negedge clk);
    check("idle_after_rot", 32'(dbg_state), 32'd0);

    // backpressure on source 1
    dst_req = 1'b1;
    wait_src_req(1);
    dst_req = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_state", 32'(dbg_state), 32'd2);
    check("hold_src_req", 32'(src_req), 32'd0);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_no_ack", 32'(dst_ack), 32'd0);
    check("hold_sb_depth", 32'(exp_q.size()), 32'd1);
    held = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("hold_dout", dst_dout, held);
    repeat (7) @(negedge clk);
    check("hold_dout_stable", dst_dout, held);
    check("hold_state_late", 32'(dbg_state), 32'd2);
    dst_req = 1'b1;
    @(negedge clk);
    check("resume_ack", 32'(dst_ack), 32'd1);
    dst_req = 1'b0;
    @(negedge clk);

    // stray acks: granted index while idle, non-granted index while granted
    run_tokens(2);
    @(negedge clk);
    auto_en = 4'b1110;
    man_ack = 4'b0001;
    @(negedge clk);
    man_ack = '0;
    check("idle_ack_state", 32'(dbg_state), 32'd0);
    check("idle_ack_dout", dst_dout, last_exp);
    dst_req = 1'b1;
    wait_src_req(0);
    man_ack = 4'b0100;
    @(negedge clk);
    man_ack = '0;
    check("stray_dout", dst_dout, last_exp);
    check("stray_grant", 32'(grant_id), 32'd0);
    check("stray_src_req", 32'(src_req), 32'b0001);
    check("stray_state", 32'(dbg_state), 32'd1);
    auto_en = 4'hF;
    wait_acks(1);
    @(negedge clk);

    // reset while source 3 is requested
    run_tokens(2);
    @(negedge clk);
    auto_en = 4'b0111;
    dst_req = 1'b1;
    wait_src_req(3);
    rst     = 1'b1;
    man_ack = 4'b1000;
    dst_req = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    man_ack = '0;
    check_reset("midreset");
    rot_base = 0;
    base_cnt = ack_count;
    auto_en  = 4'hF;
    dst_req  = 1'b1;
    wait_src_req(0);
    check("post_reset_grant", 32'(grant_id), 32'd0);
    check("post_reset_req", 32'(src_req), 32'b0001);
    wait_acks(1);
    @(negedge clk);

`ifdef RR_SCHED_TIMEOUT_EN
    // source 1 never acks: skipped after 16 cycles, retried next rotation
    auto_en = 4'b1101;
    dst_req = 1'b1;
    wait_src_req(1);
    hi = 1;
    for (int k = 0; k < 60 && src_req[1]; k++) begin
      @(negedge clk);
      if (src_req[1]) hi++;
    end
    check("tmo_req_cycles", 32'(hi), 32'd16);
    check("tmo_pulse", 32'(timeout), 32'd1);
    check("tmo_state", 32'(dbg_state), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("tmo_pulse_end", 32'(timeout), 32'd0);
    check("tmo_next_grant", 32'(grant_id), 32'd2);
    check("tmo_next_req", 32'(src_req), 32'b0100);
    rot_base = 2;
    base_cnt = ack_count;
    auto_en  = 4'hF;
    wait_acks(4);
    @(negedge clk);
`else
    // without the skip feature a silent source stalls indefinitely
    auto_en = 4'b1101;
    dst_req = 1'b1;
    wait_src_req(1);
    hi = 0;
    repeat (20) @(negedge clk);
    check("stall_req", 32'(src_req), 32'b0010);
    check("stall_timeout", 32'(timeout), 32'd0);
    check("stall_state", 32'(dbg_state), 32'd1);
    auto_en = 4'hF;
    wait_acks(4);
    @(negedge clk);
`endif

    // throughput: 5000 back-to-back tokens
    start_cnt = ack_count;
    gap_chk   = 1'b1;
    run_tokens(5000);
    gap_chk   = 1'b0;
    check("tput_count", 32'(ack_count - start_cnt), 32'd5000);
    span = (last_cyc > first_cyc) ? (last_cyc - first_cyc) : 1;
    check("tput_pct_x100", 32'((4999 * 10000) / span), 32'd2500);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(dbg_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
